// File: rtl/pkt_store_pkg.sv
// Shared definitions for the packet store-and-forward buffer: read FSM state
// codes, storage entry width helper and statistics counter width.
package pkt_store_pkg;

  typedef logic [1:0] rd_state_t;

  localparam rd_state_t ST_IDLE = 2'd0;
  localparam rd_state_t ST_FWD  = 2'd1;
  localparam rd_state_t ST_DROP = 2'd2;

  localparam int STAT_W = 16;

  // Each stored entry carries one end-of-packet flag above the data byte.
  function automatic int entryWidth(input int dataW);
    return dataW + 1;
  endfunction

endpackage

// File: rtl/pkt_store_ram.sv
// Simple dual-port storage for the packet buffer: one write port and one
// registered read port, written so that it maps onto block RAM.
module pkt_store_ram
  import pkt_store_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int WIDTH  = entryWidth(8)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/pkt_store_fifo.sv
// Packet store-and-forward byte buffer: holds whole packets, forwards or drops
// the head packet. Optional statistics counters under PKT_STORE_STATS_EN.
module pkt_store_fifo
  import pkt_store_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 11,
  parameter int CNT_W      = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rx_dv,
  input  logic              i_fifo_read,
  input  logic              i_drop,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_dv,
  output logic              o_tx_eop,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_pkt_avail,
  output logic              o_overflow
`ifdef PKT_STORE_STATS_EN
  ,
  output logic [STAT_W-1:0] o_fwd_pkts,
  output logic [STAT_W-1:0] o_drop_pkts,
  output logic [STAT_W-1:0] o_trunc_pkts
`endif
);

  localparam int ENTRY_W = entryWidth(DATA_W);
  localparam int DEPTH   = 1 << DEPTH_LOG2;

  logic [DEPTH_LOG2:0] r_wptr, r_rptr, w_used;
  logic [DATA_W-1:0]   r_stg_data;
  logic                r_stg_vld, r_discard, r_overflow;
  logic [CNT_W-1:0]    r_pkt_cnt;
  rd_state_t           r_state, w_state_nxt;
  logic                r_pop_d, r_tx_dv;
  logic [ENTRY_W-1:0]  w_rd_q;
  logic                w_empty, w_full, w_last_free;
  logic                w_wr_en, w_wr_eop, w_trunc, w_lost;
  logic                w_pop, w_eop_seen, w_cnt_inc, w_cnt_dec;

  assign w_used      = r_wptr - r_rptr;
  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]) &&
                       (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]);
  assign w_last_free = (w_used == (DEPTH_LOG2+1)'(DEPTH - 1));

  // A staged byte that lands in the last free slot mid-packet closes the packet early.
  assign w_wr_en  = r_stg_vld && !w_full;
  assign w_trunc  = w_wr_en && w_last_free && i_rx_dv;
  assign w_lost   = r_stg_vld && w_full;
  assign w_wr_eop = !i_rx_dv || w_trunc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr     <= '0;
      r_stg_data <= '0;
      r_stg_vld  <= 1'b0;
      r_discard  <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_stg_data <= i_rx_data;
      r_stg_vld  <= i_rx_dv && !r_discard && !w_trunc && !w_lost;
      if (w_wr_en) r_wptr <= r_wptr + (DEPTH_LOG2+1)'(1);
      if (!i_rx_dv) r_discard <= 1'b0;
      else if (w_trunc || w_lost) r_discard <= 1'b1;
      if (w_trunc || w_lost) r_overflow <= 1'b1;
    end
  end

  pkt_store_ram #(
    .ADDR_W (DEPTH_LOG2),
    .WIDTH  (ENTRY_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wptr[DEPTH_LOG2-1:0]),
    .i_wdata ({w_wr_eop, r_stg_data}),
    .i_re    (w_pop),
    .i_raddr (r_rptr[DEPTH_LOG2-1:0]),
    .o_rdata (w_rd_q)
  );

  // The eop flag of a popped entry is only visible one cycle later, so popping pauses then.
  assign w_eop_seen = r_pop_d && w_rd_q[DATA_W];
  assign w_pop      = !w_eop_seen && !w_empty &&
                      (((r_state == ST_FWD) && i_fifo_read) || (r_state == ST_DROP));
  assign w_cnt_inc  = w_wr_en && w_wr_eop;
  assign w_cnt_dec  = w_eop_seen;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_pkt_cnt != '0) begin
          if (i_drop) w_state_nxt = ST_DROP;
          else if (i_fifo_read) w_state_nxt = ST_FWD;
        end
      end
      ST_FWD, ST_DROP: if (w_eop_seen) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_rptr    <= '0;
      r_pop_d   <= 1'b0;
      r_tx_dv   <= 1'b0;
      r_pkt_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pop_d <= w_pop;
      r_tx_dv <= w_pop && (r_state == ST_FWD);
      if (w_pop) r_rptr <= r_rptr + (DEPTH_LOG2+1)'(1);
      if (w_cnt_inc && !w_cnt_dec) r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
      else if (!w_cnt_inc && w_cnt_dec) r_pkt_cnt <= r_pkt_cnt - CNT_W'(1);
    end
  end

  assign o_tx_dv     = r_tx_dv;
  assign o_tx_data   = r_tx_dv ? w_rd_q[DATA_W-1:0] : '0;
  assign o_tx_eop    = r_tx_dv && w_rd_q[DATA_W];
  assign o_empty     = w_empty;
  assign o_full      = w_full;
  assign o_pkt_avail = (r_pkt_cnt != '0);
  assign o_overflow  = r_overflow;

`ifdef PKT_STORE_STATS_EN
  logic [STAT_W-1:0] r_fwd_pkts, r_drop_pkts, r_trunc_pkts;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_fwd_pkts   <= '0;
      r_drop_pkts  <= '0;
      r_trunc_pkts <= '0;
    end else begin
      if (w_eop_seen && (r_state == ST_FWD) && (r_fwd_pkts != '1))
        r_fwd_pkts <= r_fwd_pkts + STAT_W'(1);
      if (w_eop_seen && (r_state == ST_DROP) && (r_drop_pkts != '1))
        r_drop_pkts <= r_drop_pkts + STAT_W'(1);
      if (w_trunc && (r_trunc_pkts != '1))
        r_trunc_pkts <= r_trunc_pkts + STAT_W'(1);
    end
  end

  assign o_fwd_pkts   = r_fwd_pkts;
  assign o_drop_pkts  = r_drop_pkts;
  assign o_trunc_pkts = r_trunc_pkts;
`endif

endmodule

// File: tb/tb_pkt_store_fifo.sv
// Self-checking bench for pkt_store_fifo (DEPTH_LOG2=4) against a queue-based
// packet model; statistics ports are checked when PKT_STORE_STATS_EN is defined.
module tb_pkt_store_fifo;

  localparam int DATA_W     = 8;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [7:0] rxData = '0;
  logic       rxDv = 1'b1;
  logic       fifoRead = 1'b0;
  logic       drop = 1'b0;
  logic [7:0] txData;
  logic       txDv, txEop, empty, full, pktAvail, overflow;
`ifdef PKT_STORE_STATS_EN
  logic [15:0] fwdPkts, dropPkts, truncPkts;
  int modelFwd = 0, modelDrop = 0, modelTrunc = 0;
`endif

  always #5 clk = ~clk;

  pkt_store_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .CNT_W      (8)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_rx_data   (rxData),
    .i_rx_dv     (rxDv),
    .i_fifo_read (fifoRead),
    .i_drop      (drop),
    .o_tx_data   (txData),
    .o_tx_dv     (txDv),
    .o_tx_eop    (txEop),
    .o_empty     (empty),
    .o_full      (full),
    .o_pkt_avail (pktAvail),
    .o_overflow  (overflow)
`ifdef PKT_STORE_STATS_EN
    ,
    .o_fwd_pkts   (fwdPkts),
    .o_drop_pkts  (dropPkts),
    .o_trunc_pkts (truncPkts)
`endif
  );

  int totalChecks = 0;
  int badChecks   = 0;
  int cyc         = 0;

  // Model state: stored entries as {eop, byte}, expected and observed tx streams.
  logic [8:0] modelQ[$];
  logic [8:0] expQ[$];
  logic [8:0] gotQ[$];
  int         gotCyc[$];
  bit         modelOvf = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (txDv === 1'b1) begin
      gotQ.push_back({txEop, txData});
      gotCyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends one packet and records what the buffer should keep: as many bytes as
  // there is room for, the last kept byte marked as end of packet.
  task automatic applyStimulus(input int len, input logic [7:0] base, input bit rnd);
    int room;
    int n;
    logic [7:0] b;
    room = DEPTH - modelQ.size();
    n = (len < room) ? len : room;
    for (int i = 0; i < len; i++) begin
      b = rnd ? 8'($urandom_range(0, 255)) : base + 8'(i);
      if (i < n) modelQ.push_back({(i == n - 1), b});
      @(posedge clk);
      #1;
      rxDv = 1'b1;
      rxData = b;
    end
    @(posedge clk);
    #1;
    rxDv = 1'b0;
    rxData = '0;
    if (len > room) begin
      modelOvf = 1'b1;
`ifdef PKT_STORE_STATS_EN
      if (room > 0) modelTrunc++;
`endif
    end
  endtask

  function automatic void modelPop(input bit fwd);
    logic [8:0] e;
    while (modelQ.size() > 0) begin
      e = modelQ.pop_front();
      if (fwd) expQ.push_back(e);
      if (e[8]) break;
    end
`ifdef PKT_STORE_STATS_EN
    if (fwd) modelFwd++;
    else modelDrop++;
`endif
  endfunction

  task automatic waitBytes(input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #1;
      if (gotQ.size() >= n) break;
    end
    settle(4);
  endtask

  task automatic compareOut(input string tag);
    int m;
    checkOutput({tag, "Len"}, gotQ.size(), expQ.size());
    m = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int i = 0; i < m; i++) checkOutput(tag, 32'(gotQ[i]), 32'(expQ[i]));
    gotQ.delete();
    gotCyc.delete();
    expQ.delete();
  endtask

  task automatic checkFlags(input string tag);
    bit anyEop;
    anyEop = 1'b0;
    foreach (modelQ[i]) if (modelQ[i][8]) anyEop = 1'b1;
    checkOutput({tag, "Empty"}, empty, modelQ.size() == 0);
    checkOutput({tag, "Full"}, full, modelQ.size() == DEPTH);
    checkOutput({tag, "PktAvail"}, pktAvail, anyEop);
    checkOutput({tag, "Overflow"}, overflow, modelOvf);
  endtask

  task automatic doReset(input string tag);
    rxDv = 1'b1;
    rstN = 1'b0;
    settle(2);
    rstN = 1'b1;
    modelQ.delete();
    modelOvf = 1'b0;
`ifdef PKT_STORE_STATS_EN
    modelFwd = 0;
    modelDrop = 0;
    modelTrunc = 0;
`endif
    settle(2);
    rxDv = 1'b0;
    settle(2);
    gotQ.delete();
    gotCyc.delete();
    checkOutput({tag, "TxDv"}, txDv, 1'b0);
    checkOutput({tag, "TxEop"}, txEop, 1'b0);
    checkOutput({tag, "TxData"}, txData, 8'h00);
    checkFlags(tag);
  endtask

  initial begin
    int lenA;
    int lenB;
    int total;
    bit gapOk;

    doReset("reset");

    // Plain forward of 0x11..0x15 as one burst.
    applyStimulus(5, 8'h11, 1'b0);
    settle(3);
    checkFlags("fwdPre");
    modelPop(1'b1);
    fifoRead = 1'b1;
    waitBytes(5, 60);
    fifoRead = 1'b0;
    if (gotCyc.size() == 5) checkOutput("fwdBurst", gotCyc[4] - gotCyc[0], 4);
    else checkOutput("fwdBurstCount", gotCyc.size(), 5);
    compareOut("fwd");
    checkFlags("fwdPost");

    // Stored data and a half-received packet both vanish across reset.
    applyStimulus(4, 8'h30, 1'b0);
    @(posedge clk);
    #1;
    rxDv = 1'b1;
    rxData = 8'h55;
    settle(2);
    doReset("rstMid");
    fifoRead = 1'b1;
    settle(12);
    fifoRead = 1'b0;
    checkOutput("rstNoData", gotQ.size(), 0);
    gotQ.delete();
    gotCyc.delete();

    // Stall the forward for three cycles after two bytes.
    applyStimulus(8, 8'h00, 1'b1);
    settle(3);
    modelPop(1'b1);
    fifoRead = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (gotQ.size() >= 2) break;
    end
    fifoRead = 1'b0;
    @(negedge clk);
    @(negedge clk);
    gapOk = (txDv == 1'b0);
    @(negedge clk);
    gapOk = gapOk && (txDv == 1'b0);
    checkOutput("stallGap", gapOk, 1'b1);
    @(posedge clk);
    #1;
    fifoRead = 1'b1;
    waitBytes(8, 60);
    fifoRead = 1'b0;
    compareOut("stall");
    checkFlags("stallPost");

    // drop and fifo_read together: A is discarded, B forwarded.
    applyStimulus(4, 8'hA0, 1'b0);
    applyStimulus(3, 8'hB0, 1'b0);
    settle(3);
    checkFlags("dropPre");
    modelPop(1'b0);
    modelPop(1'b1);
    drop = 1'b1;
    fifoRead = 1'b1;
    settle(1);
    drop = 1'b0;
    waitBytes(3, 60);
    fifoRead = 1'b0;
    compareOut("dropPrio");
    checkFlags("dropPost");

    // Write a packet while the previous one is being forwarded with random stalls.
    for (int it = 0; it < 8; it++) begin
      lenA = $urandom_range(1, 7);
      lenB = $urandom_range(1, 7);
      total = lenA + lenB;
      applyStimulus(lenA, 8'h00, 1'b1);
      fork
        applyStimulus(lenB, 8'h00, 1'b1);
        begin
          for (int c = 0; c < total + 6; c++) begin
            @(posedge clk);
            #1;
            fifoRead = ($urandom_range(0, 3) != 0);
          end
        end
      join
      modelPop(1'b1);
      modelPop(1'b1);
      fifoRead = 1'b1;
      waitBytes(total, 200);
      fifoRead = 1'b0;
      compareOut("conc");
      checkFlags("concPost");
    end
`ifdef PKT_STORE_STATS_EN
    checkOutput("statFwd", fwdPkts, modelFwd);
    checkOutput("statDrop", dropPkts, modelDrop);
`endif

    // Exactly filling the buffer is not an overflow.
    applyStimulus(DEPTH, 8'h00, 1'b1);
    settle(3);
    checkFlags("exactFill");
    modelPop(1'b1);
    fifoRead = 1'b1;
    waitBytes(DEPTH, 100);
    fifoRead = 1'b0;
    compareOut("exactFwd");
    checkFlags("exactPost");

    // 20 bytes into 16 entries: truncated with eop on the 16th byte.
    applyStimulus(20, 8'h40, 1'b0);
    settle(3);
    checkFlags("ovf");
    modelPop(1'b1);
    fifoRead = 1'b1;
    waitBytes(DEPTH, 100);
    fifoRead = 1'b0;
    compareOut("ovfFwd");
    checkFlags("ovfPost");
`ifdef PKT_STORE_STATS_EN
    checkOutput("statTrunc", truncPkts, modelTrunc);
    checkOutput("statFwdEnd", fwdPkts, modelFwd);
`endif

    doReset("finalReset");

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
